// File: rtl/cp0_pkg.sv
// cp0_pkg: exception codes, Status bit positions and nest-depth sizing shared by cp0 and int_ctrl
package cp0_pkg;
    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_SYSCALL = 5'd8,
        EXC_BREAK   = 5'd9,
        EXC_TEQ     = 5'd13
    } exc_code_t;
    localparam int STATUS_IE = 0;
    localparam int STATUS_IM = 8;
    localparam int DEPTH_W = 3;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: two-flop synchronizer plus rising-edge detector for one interrupt line
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic rise
);
    logic s1, s2, prev;
    logic [2:0] warm;
    // warm fills with ones after reset so the history flop holds a real sample
    // before edges are reported; a line held high across reset is not an edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
            warm <= '0;
        end else begin
            s1   <= irq;
            s2   <= s1;
            prev <= s2;
            warm <= {warm[1:0], 1'b1};
        end
    assign rise = s2 & ~prev & warm[2];
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: trap/interrupt arbitration, pending tracking and nest-depth bookkeeping for CP0
module int_ctrl
    import cp0_pkg::*;
#(
    parameter int NIRQ = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic            syscall,
    input  logic            brk,
    input  logic            teq,
    input  logic            teq_eq,
    input  logic            eret_in,
    input  logic [31:0]     status,
    output logic            exception,
    output logic [4:0]      cause,
    output logic            eret,
    output logic [NIRQ-1:0] ip,
    output logic [NIRQ-1:0] irq_taken,
    output logic            in_handler,
    output logic            nest_err
);
    logic [NIRQ-1:0] rise, pending, elig, grant;
    logic [DEPTH_W-1:0] depth;
    logic trap, take_int;
    for (genvar i = 0; i < NIRQ; i++) begin : g_sync
        irq_sync u_sync (.clk(clk), .rst(rst), .irq(irq[i]), .rise(rise[i]));
    end
    // arbitration: traps beat interrupts, eret blocks interrupts, lowest eligible line wins
    always_comb begin
        trap       = ~rst & (syscall | brk | (teq & teq_eq));
        elig       = pending & status[STATUS_IM +: NIRQ] & {NIRQ{status[STATUS_IE] & ~in_handler}};
        grant      = elig & (-elig);
        take_int   = ~rst & ~trap & ~eret_in & (|elig);
        irq_taken  = take_int ? grant : '0;
        exception  = trap | take_int;
        cause      = ~trap ? EXC_INT : syscall ? EXC_SYSCALL : brk ? EXC_BREAK : EXC_TEQ;
        in_handler = depth != '0;
        ip         = pending;
        eret       = eret_in;
    end
    // pending set-wins, saturating nest depth and sticky nesting error
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pending  <= '0;
            depth    <= '0;
            nest_err <= 1'b0;
        end else begin
            pending  <= (pending & ~irq_taken) | rise;
            depth    <= (exception & ~eret_in) ? ((depth == DEPTH_MAX) ? depth : depth + 1'b1)
                      : (eret_in & ~exception) ? ((depth == '0) ? depth : depth - 1'b1)
                      : depth;
            nest_err <= nest_err | (exception & (depth == DEPTH_MAX)) | (eret_in & (depth == '0));
        end
endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter NIRQ, default 5, the number of external interrupt lines.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port irq  in  NIRQ  external interrupt lines, asynchronous to clk, rising-edge significant.
REQ-005 SHALL have port syscall, brk, teq  in  1 each  decoded trap instructions of the current cycle.
REQ-006 SHALL have port teq_eq  in  1  operand equality for teq (rs == rt).
REQ-007 SHALL have port eret_in  in  1  decoded eret of the current cycle.
REQ-008 SHALL have port status  in  32  CP0 Status; bit 0 is global IE, bits 8+i are the per-line masks IM[i].
REQ-009 SHALL have port exception  out  1  exception request to CP0, valid in the current cycle.
REQ-010 SHALL have port cause  out  5  exception code to CP0; 0 when exception is low.
REQ-011 SHALL have port eret  out  1  eret forwarded to CP0.
REQ-012 SHALL have port ip  out  NIRQ  pending-interrupt vector for the Cause IP field.
REQ-013 SHALL have port irq_taken  out  NIRQ  one-hot, one-cycle pulse naming the interrupt accepted.
REQ-014 SHALL have port in_handler  out  1  high while nest depth is non-zero.
REQ-015 SHALL have port nest_err  out  1  sticky; set on nest-depth overflow or eret at depth 0.

Function
REQ-016 SHALL pass each irq bit through a 2-flop synchronizer, then a rising-edge detector on the synchronized value.
REQ-017 SHALL set pending[i] on a detected edge and clear it when line i is taken; if both happen in the same cycle, set wins.
REQ-018 SHALL form the trap condition as syscall, brk, or (teq and teq_eq), evaluated combinationally in the same cycle.
REQ-019 SHALL prioritize syscall (cause 01000) over brk (01001) over teq (01101) over interrupts (cause 00000).
REQ-020 SHALL treat line i as eligible when pending[i], status[0], status[8+i] and in_handler is low all hold; the lowest-index eligible line wins.
REQ-021 SHALL drive exception high combinationally when a trap condition is true or any line is eligible, with cause chosen per REQ-019.
REQ-022 SHALL pulse irq_taken[i] only in a cycle where an interrupt is accepted, never in a cycle where a trap is accepted.
REQ-023 SHALL keep a 3-bit nest depth counter: +1 on each accepted exception, -1 on eret_in; it saturates at 7.
REQ-024 SHALL set nest_err when an exception is accepted at depth 7, or when eret_in is seen at depth 0; depth stays 0 in the latter case.
REQ-025 SHALL accept traps at any depth and defer interrupts while depth is non-zero, keeping them pending.
REQ-026 SHALL drive eret = eret_in combinationally in all cases.
REQ-027 SHALL give eret_in precedence over interrupts if both occur in one cycle: no interrupt is taken and depth decrements.
REQ-028 SHALL give a trap plus eret_in in one cycle a net depth change of 0; the trap is still reported.
REQ-029 SHALL drive ip = pending.

Reset
REQ-030 SHALL on rst clear the synchronizers, edge-detect history, pending, depth and nest_err immediately.
REQ-031 SHALL hold exception=0, cause=0, irq_taken=0, ip=0, in_handler=0 and nest_err=0 while rst is high, with input traps ignored.
REQ-032 SHALL NOT report a line held high across reset release as an edge.

Structure
REQ-033 SHALL take cause codes (INT, SYSCALL, BREAK, TEQ), the Status bit indices (IE=0, IM base=8) and the depth width from a shared package, cp0_pkg, which cp0 also uses.
REQ-034 SHALL implement the per-line synchronizer and edge detector as a sub-module, irq_sync, instantiated NIRQ times.

Verification
REQ-035 SHALL check: syscall=1 at depth 0 -> exception=1, cause=01000 the same cycle, in_handler=1 the next cycle.
REQ-036 SHALL check: with status=0x0000_0101, an irq[0] rise -> exception=1, cause=0, irq_taken=00001 on the 3rd clk edge after the rise, then ip[0]=0.
REQ-037 SHALL check: irq[1] and irq[3] rise together with status=0x0000_0A01 -> irq[1] taken first; irq[3] taken only after eret_in returns depth to 0.
REQ-038 SHALL check: irq[2] rises with status[0]=0 -> no exception and ip[2]=1; status changed to 0x0000_0401 -> taken next cycle.
REQ-039 SHALL check: eret_in at depth 0 -> eret=1, nest_err=1, depth stays 0; 8 nested syscalls -> depth 7 and nest_err=1.
REQ-040 SHALL check: rst asserted mid-handler with ip=0x04 -> all outputs 0 immediately; irq held high through reset release -> no exception.
